// File: rtl/cdr_decision_vote.sv
// Symbol decision: counts i_ce strobes per symbol and majority-votes a 1/3/5 sample window centred mid-symbol.
// Latency: o_data/o_valid/o_flag appear one clock after the strobe that closes the vote window.
// Backpressure: none; i_ce gates all progress, and without i_ce the counter and accumulator hold.
//
// Ports:
//   i_clk, i_rst     clock (rising edge), asynchronous active-low reset
//   i_phase, i_ce    phase sign and its sample strobe
//   i_nb_P           samples per symbol (2..2^CNT_W-1), shadowed per symbol
//   i_vote           window: 0 -> 1 sample, 1 -> 3 samples, 2/3 -> 5 samples, shadowed per symbol
//   i_invert         output polarity, shadowed per symbol
//   i_adj            timing nudge sampled at the wrap: 01 advance, 10 retard
//   i_flag           frame-start pulse, re-emitted on o_flag with the next decision
//   o_data, o_valid  decided bit (held) and its one-cycle valid pulse
//   o_flag           frame-start marker aligned with o_valid
//   o_cnt            current sample counter (debug)
module cdr_decision_vote #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_phase,
    input  logic             i_ce,
    input  logic [CNT_W-1:0] i_nb_P,
    input  logic [1:0]       i_vote,
    input  logic             i_invert,
    input  logic [1:0]       i_adj,
    input  logic             i_flag,
    output logic             o_data,
    output logic             o_valid,
    output logic             o_flag,
    output logic [CNT_W-1:0] o_cnt
);

    // Shadow configuration, refreshed at each symbol wrap.
    logic [CNT_W-1:0] nb_q;
    logic [1:0]       vote_q;
    logic             inv_q;
    logic             loaded;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       acc;
    logic             retard_used;
    logic             pending;

    // Effective config: before the first load the live inputs are used so the
    // very first post-reset edge already counts and votes with them.
    logic [CNT_W-1:0] nb_e;
    logic [1:0]       vote_e;
    logic             inv_e;
    logic [CNT_W-1:0] nb_m1;
    logic [CNT_W-1:0] mid;
    logic [1:0]       h_raw;
    logic [1:0]       h_sel;
    logic [CNT_W-1:0] win_lo;
    logic [CNT_W-1:0] win_hi;
    logic             wrap;
    logic             in_win;
    logic             decide;
    logic [2:0]       ones;
    logic             maj;

    always_comb begin
        nb_e   = loaded ? nb_q   : i_nb_P;
        vote_e = loaded ? vote_q : i_vote;
        inv_e  = loaded ? inv_q  : i_invert;

        nb_m1 = nb_e - CNT_W'(1);
        mid   = nb_m1 >> 1;

        case (vote_e)
            2'd0:    h_raw = 2'd0;
            2'd1:    h_raw = 2'd1;
            default: h_raw = 2'd2;
        endcase
        // Short symbols cannot fit a wide window; clamp the half-width to mid.
        if (mid < CNT_W'(h_raw)) h_sel = mid[1:0];
        else                     h_sel = h_raw;

        win_lo = mid - CNT_W'(h_sel);
        win_hi = mid + CNT_W'(h_sel);

        // During a retard hold the counter still sits at the old nb-1; the
        // extra strobe always wraps, even if the freshly loaded nb differs.
        wrap   = i_ce && (retard_used || (cnt == nb_m1));
        in_win = i_ce && (cnt >= win_lo) && (cnt <= win_hi);
        decide = i_ce && (cnt == win_hi);

        ones = acc + {2'b00, i_phase};
        maj  = ones > {1'b0, h_sel};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            nb_q        <= '0;
            vote_q      <= '0;
            inv_q       <= 1'b0;
            loaded      <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            retard_used <= 1'b0;
            pending     <= 1'b0;
            o_data      <= 1'b0;
            o_valid     <= 1'b0;
            o_flag      <= 1'b0;
        end else begin
            loaded  <= 1'b1;
            o_valid <= 1'b0;
            o_flag  <= 1'b0;

            if (!loaded || wrap) begin
                nb_q   <= i_nb_P;
                vote_q <= i_vote;
                inv_q  <= i_invert;
            end

            if (i_ce) begin
                if (wrap) begin
                    if (retard_used) begin
                        cnt         <= '0;
                        retard_used <= 1'b0;
                    end else if (i_adj == 2'b01) begin
                        cnt <= CNT_W'(1);
                    end else if (i_adj == 2'b10) begin
                        retard_used <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            if (decide)                acc <= '0;
            else if (in_win && i_phase) acc <= acc + 3'd1;

            if (decide) begin
                o_data  <= maj ^ inv_e;
                o_valid <= 1'b1;
                o_flag  <= pending;
                // A flag landing on the decision edge belongs to the next symbol.
                pending <= i_flag;
            end else if (i_flag) begin
                pending <= 1'b1;
            end
        end
    end

    assign o_cnt = cnt;

endmodule

// File: tb/tb_cdr_decision_vote.sv
module tb_cdr_decision_vote;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       phase = 1'b0;
    logic       ce = 1'b0;
    logic [5:0] nb_p = 6'd8;
    logic [1:0] vote = 2'd0;
    logic       inv = 1'b1;
    logic [1:0] adj = 2'd0;
    logic       flag = 1'b0;
    logic       o_data, o_valid, o_flag;
    logic [5:0] o_cnt;

    cdr_decision_vote #(.CNT_W(6)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_phase(phase), .i_ce(ce), .i_nb_P(nb_p),
        .i_vote(vote), .i_invert(inv), .i_adj(adj), .i_flag(flag),
        .o_data(o_data), .o_valid(o_valid), .o_flag(o_flag), .o_cnt(o_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the symbol, the shadowed settings and
    // the window samples collected so far; decisions count ones in the window.
    int m_cnt, m_nb, m_vote, m_inv;
    bit m_loaded, m_ret, m_pend;
    bit win[$];
    int e_valid, e_flag, e_data;
    int gcyc = 0;

    task automatic model_reset();
        m_cnt = 0; m_nb = 0; m_vote = 0; m_inv = 0;
        m_loaded = 0; m_ret = 0; m_pend = 0;
        win.delete();
        e_valid = 0; e_flag = 0; e_data = 0;
    endtask

    function automatic int half_of(int md, int nbv);
        int h, mid;
        mid = (nbv - 1) / 2;
        h = (md == 0) ? 0 : (md == 1) ? 1 : 2;
        return (h > mid) ? mid : h;
    endfunction

    function automatic int eff_hi();
        int nbv, md;
        nbv = m_loaded ? m_nb : int'(nb_p);
        md  = m_loaded ? m_vote : int'(vote);
        return (nbv - 1) / 2 + half_of(md, nbv);
    endfunction

    task automatic model_step();
        int nbv, md, iv, half, mid, ones;
        bit wrap;
        nbv = m_loaded ? m_nb : int'(nb_p);
        md  = m_loaded ? m_vote : int'(vote);
        iv  = m_loaded ? m_inv : int'(inv);
        mid = (nbv - 1) / 2;
        half = half_of(md, nbv);
        e_valid = 0; e_flag = 0;
        wrap = ce && (m_ret || m_cnt == nbv - 1);
        if (ce && m_cnt >= mid - half && m_cnt <= mid + half) win.push_back(phase);
        if (ce && m_cnt == mid + half) begin
            ones = 0;
            foreach (win[i]) ones += int'(win[i]);
            e_data = int'(ones > half) ^ iv;
            e_valid = 1;
            e_flag = int'(m_pend);
            m_pend = flag;
            win.delete();
        end else if (flag) begin
            m_pend = 1;
        end
        if (ce) begin
            if (!wrap) m_cnt++;
            else if (m_ret) begin m_cnt = 0; m_ret = 0; end
            else if (adj == 2'b01) m_cnt = 1;
            else if (adj == 2'b10) m_ret = 1;
            else m_cnt = 0;
        end
        if (!m_loaded || wrap) begin m_nb = nb_p; m_vote = vote; m_inv = inv; end
        m_loaded = 1;
    endtask

    // One clock: inputs already driven at the preceding negedge.
    task automatic step();
        if (rst_n) model_step();
        @(posedge clk);
        @(negedge clk);
        chk("valid", o_valid, e_valid);
        chk("flag", o_flag, e_flag);
        chk("data", o_data, e_data);
        chk("cnt", o_cnt, m_cnt);
    endtask

    // Runs until o_valid; phase follows a per-count pattern, ce every 'every' clocks.
    task automatic run_to_valid(input int every, input logic [15:0] pat, input bit fl_dec,
                                output int clocks, output int strobes, output bit saw_flag);
        clocks = 0; strobes = 0; saw_flag = 0;
        for (int k = 0; k < 400; k++) begin
            ce = (gcyc % every) == 0;
            gcyc++;
            phase = pat[m_cnt & 15];
            flag = fl_dec && ce && (m_cnt == eff_hi());
            step();
            clocks++;
            if (ce) strobes++;
            if (o_valid) begin
                saw_flag = o_flag;
                flag = 1'b0;
                return;
            end
        end
        flag = 1'b0;
        chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int c, s;
        bit f;
        model_reset();
        @(negedge clk);
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_flag", o_flag, 0);
        chk("rst_cnt", o_cnt, 0);

        // Baseline: nb 8, single sample, inverted polarity.
        nb_p = 8; vote = 0; inv = 1; ce = 1; rst_n = 1;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("base_period", c, 8);
        chk("base_data_inv", o_data, 0);
        inv = 0;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("base_data", o_data, 1);

        // Majority over 3 and 5 samples.
        vote = 1;
        run_to_valid(1, 16'h0014, 0, c, s, f);
        run_to_valid(1, 16'h0014, 0, c, s, f);
        chk("maj3_101", o_data, 1);
        run_to_valid(1, 16'h0008, 0, c, s, f);
        chk("maj3_010", o_data, 0);
        vote = 2;
        run_to_valid(1, 16'h0026, 0, c, s, f);
        run_to_valid(1, 16'h0026, 0, c, s, f);
        chk("maj5_11001", o_data, 1);

        // Strobe gaps.
        vote = 0;
        run_to_valid(4, 16'hFFFF, 0, c, s, f);
        run_to_valid(4, 16'hFFFF, 0, c, s, f);
        chk("gap_period_clk", c, 32);
        chk("gap_period_strobes", s, 8);

        // Clamp: nb 4 in mode 2 votes over counts 0..2.
        nb_p = 4; vote = 2;
        run_to_valid(1, 16'h0003, 0, c, s, f);
        run_to_valid(1, 16'h0003, 0, c, s, f);
        chk("clamp_period", c, 4);
        chk("clamp_data1", o_data, 1);
        run_to_valid(1, 16'h0009, 0, c, s, f);
        chk("clamp_data0", o_data, 0);

        // Nudges.
        nb_p = 8; vote = 0;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        adj = 2'b01;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("advance_spacing", s, 7);
        adj = 2'b00;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("normal_spacing", s, 8);
        adj = 2'b10;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("retard_spacing", s, 9);
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("retard_held_spacing", s, 9);
        adj = 2'b00;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("after_retard_spacing", s, 8);

        // Flags.
        ce = 1; flag = 1; step(); flag = 0;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("flag_mid", int'(f), 1);
        run_to_valid(1, 16'hFFFF, 1, c, s, f);
        chk("flag_on_dec_same", int'(f), 0);
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("flag_on_dec_next", int'(f), 1);
        ce = 1; flag = 1; step(); flag = 0; step(); flag = 1; step(); flag = 0;
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("flag_double_once", int'(f), 1);
        run_to_valid(1, 16'hFFFF, 0, c, s, f);
        chk("flag_double_none", int'(f), 0);

        // Asynchronous reset in the middle of a 3-sample window.
        vote = 1;
        run_to_valid(1, 16'h0014, 0, c, s, f);
        run_to_valid(1, 16'h0014, 0, c, s, f);
        for (int k = 0; k < 20 && m_cnt != 3; k++) begin
            ce = 1; phase = 1'b1; step();
        end
        chk("pre_rst_cnt", o_cnt, 3);
        chk("pre_rst_data", o_data, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", o_data, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_flag", o_flag, 0);
        chk("arst_cnt", o_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_to_valid(1, 16'h0014, 0, c, s, f);
        chk("post_rst_first_valid", c, 5);
        chk("post_rst_data", o_data, 1);

        // Randomized traffic: even nb keeps the decision clear of the retard hold.
        for (int k = 0; k < 1500; k++) begin
            ce    = $urandom_range(0, 3) != 0;
            phase = $urandom_range(0, 1) != 0;
            nb_p  = 6'(2 * $urandom_range(2, 8));
            vote  = 2'($urandom_range(0, 3));
            inv   = $urandom_range(0, 1) != 0;
            adj   = 2'($urandom_range(0, 3));
            flag  = $urandom_range(0, 9) == 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdr_decision_vote.md
# cdr_decision_vote

Parametrised symbol-decision stage for the CDR chain, placed after the phase detector and before chip despreading. It counts sample strobes across each symbol period and votes on a configurable window of 1, 3 or 5 samples centred on mid-symbol. Once per symbol it emits one registered bit with a valid pulse. It also supports per-symbol timing nudges (advance/retard) and carries a frame-start flag aligned to the first decision that follows it.

## Interface
- CNT_W, 6, width of symbol-period counter and of i_nb_P
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_phase  in  1  demodulated phase sign, sampled on i_ce
- i_ce  in  1  sample strobe (one pulse per oversampled point)
- i_nb_P  in  CNT_W  samples per symbol; legal range 2..2^CNT_W-1
- i_vote  in  2  window mode: 0 = 1 sample, 1 = 3 samples, 2 or 3 = 5 samples
- i_invert  in  1  1: o_data = ~majority (legacy polarity); 0: o_data = majority
- i_adj  in  2  timing nudge: 01 = advance, 10 = retard, 00/11 = none
- i_flag  in  1  frame-start pulse from upstream
- o_data  out  1  decided bit; holds between decisions
- o_valid  out  1  one-cycle pulse per decision
- o_flag  out  1  one-cycle pulse, coincident with the first o_valid after i_flag
- o_cnt  out  CNT_W  current sample counter (debug)

## Operation
- Shadow config: nb, h and inv are loaded from i_nb_P, i_vote and i_invert on the first clock edge after reset release and on every wrap event. Between loads, changes to these inputs have no effect.
- Derived values: M = (nb-1)>>1. h = 0, 1 or 2 according to the vote mode, clamped to M (so nb = 4 in mode 2 gives h = 1).
- Counter cnt advances only on i_ce, counting 0..nb-1. Wrap event: i_ce = 1 with cnt = nb-1. At wrap, cnt goes to 0 unless a nudge applies.
- Nudges: i_adj is sampled at the wrap event and honoured at most once per symbol.
  - 01 (advance): cnt wraps to 1, shortening the next symbol by one strobe.
  - 10 (retard): cnt holds at nb-1 for one extra strobe. The following strobe wraps to 0 and ignores i_adj.
- Voting: an accumulator counts ones of i_phase on each i_ce with cnt in [M-h, M+h]. It is cleared on the decision edge.
- Decision edge: i_ce = 1 with cnt = M+h. On that edge:
  - maj = (ones, including the current sample) > h.
  - o_data <= maj ^ inv.
  - o_valid <= 1.
- Flag handling:
  - i_flag sets a single pending bit; a further i_flag while pending has no effect.
  - On a decision edge with pending = 1, o_flag <= 1 and pending is cleared.
  - An i_flag arriving on the same edge as a decision applies to the next decision.
- Reset (asynchronous, any time, including mid-window): o_data = 0, o_valid = 0, o_flag = 0, o_cnt = 0. The accumulator, pending bit, nudge-used bit and config-loaded bit are also cleared. The first post-reset edge loads config and counts if i_ce = 1.

## Timing
- All outputs are registered. o_valid, o_flag and the o_data update appear in the cycle after the decision edge, so latency from the last window sample to o_valid is 1 clock.
- o_valid period equals nb i_ce strobes (nb-1 after an advance, nb+1 after a retard), independent of the i_ce duty cycle.
- o_valid and o_flag are never high for more than one consecutive cycle.
- i_ce gaps: cnt and the accumulator hold; no decision occurs without i_ce.
- nb = 2: M = 0, h = 0, single-sample decision at cnt = 0.

## Test plan
- Reset: assert i_rst = 0 mid-window (nb = 8, mode 1, cnt = 3). All outputs go to 0 without a clock edge. After release, the first o_valid arrives when cnt next reaches 4.
- Baseline: nb = 8, mode 0, i_ce every cycle, i_phase = 1, inv = 1. o_valid every 8 clocks with o_data = 0. With inv = 0 (effective after the next wrap), o_data = 1.
- Majority: nb = 8, mode 1, inv = 0. Phase 1,0,1 at cnt 2,3,4 gives o_data = 1; 0,1,0 gives 0. Mode 2 with 1,1,0,0,1 at cnt 1..5 gives 1.
- Strobe gaps and clamp: i_ce every 4th clock with nb = 8 gives an o_valid period of 32 clocks. nb = 4 in mode 2 votes over cnt 0..2.
- Nudges: with nb = 8, i_adj = 01 at wrap makes the next o_valid spacing 7 strobes; i_adj = 10 makes it 9. Holding i_adj = 10 continuously still gives exactly one retard per symbol.
- Flag: an i_flag pulse mid-symbol gives o_flag together with the next o_valid only. An i_flag on the decision edge gives o_flag on the following decision. Two i_flag pulses before one decision give a single o_flag.
